// File: rtl/viterbi_link_ctrl.sv
// viterbi_link_ctrl: frame sequencer for the encoder -> channel -> Viterbi
// decoder link. One start pulse drives a PRBS frame plus flush tail into
// the encoder, optionally corrupts a window of channel symbols, and counts
// decoded-bit mismatches against a latency-aligned reference copy.
// Optional feature macro: VITERBI_LINK_ERR_INJ_EN (channel error injection).
module viterbi_link_ctrl #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned DEC_LAT   = 24,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] err_start_i,
    input  logic [7:0]  err_len_i,
    input  logic [1:0]  err_mode_i,
    output logic        enc_bit_o,
    output logic        enc_en_o,
    input  logic        enc_valid_i,
    output logic [1:0]  chan_err_o,
    input  logic        dec_bit_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] flip_ct_o,
    output logic [15:0] err_ct_o,
    output logic        pass_o
);
    // An all-zero seed would lock the LFSR up
    localparam logic [15:0] SEED       = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LAST_BIT   = 16'(FRAME_LEN - 1);
    localparam logic [15:0] LAST_FLUSH = 16'(DEC_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t              state, state_nxt;
    logic [15:0]         cnt;
    logic [15:0]         lfsr;
    logic [DEC_LAT-1:0]  ref_pipe;
    logic [DEC_LAT-1:0]  vld_pipe;
    logic [15:0]         err_ct, err_ct_nxt;
    logic [15:0]         flip_ct;
    logic                pass_q;
    logic                start_ok;
    logic                cmp_err;

    assign start_ok = (state == IDLE) && start_i;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and sequencing outputs
    always_comb begin
        state_nxt = state;
        enc_en_o  = 1'b0;
        enc_bit_o = 1'b0;
        busy_o    = 1'b1;
        done_o    = 1'b0;
        unique case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_nxt = RUN;
            end
            RUN: begin
                enc_en_o  = 1'b1;
                enc_bit_o = lfsr[0];
                if (cnt == LAST_BIT) state_nxt = FLUSH;
            end
            FLUSH: begin
                enc_en_o = 1'b1;
                if (cnt == LAST_FLUSH) state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shared bit / flush counter; restarts at each phase boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                       cnt <= '0;
        else if (start_ok)                              cnt <= '0;
        else if (state == RUN && state_nxt == FLUSH)    cnt <= '0;
        else if (state == RUN || state == FLUSH)        cnt <= cnt + 16'd1;
    end

    // PRBS x^16+x^14+x^13+x^11+1, shifting toward bit 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               lfsr <= SEED;
        else if (start_ok)      lfsr <= SEED;
        else if (state == RUN)  lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    // Reference bit and tag pipes; only payload bits carry tag=1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_pipe <= '0;
            vld_pipe <= '0;
        end else begin
            for (int i = DEC_LAT - 1; i > 0; i--) begin
                ref_pipe[i] <= ref_pipe[i-1];
                vld_pipe[i] <= vld_pipe[i-1];
            end
            ref_pipe[0] <= enc_bit_o;
            vld_pipe[0] <= (state == RUN);
        end
    end

    assign cmp_err    = vld_pipe[DEC_LAT-1] & (dec_bit_i ^ ref_pipe[DEC_LAT-1]);
    assign err_ct_nxt = (cmp_err && err_ct != 16'hFFFF) ? err_ct + 16'd1 : err_ct;

    // Mismatch counter and pass flag; pass is visible during the DONE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_ct <= '0;
            pass_q <= 1'b0;
        end else if (start_ok) begin
            err_ct <= '0;
            pass_q <= 1'b0;
        end else begin
            err_ct <= err_ct_nxt;
            if (state == FLUSH && state_nxt == DONE) pass_q <= (err_ct_nxt == 16'h0000);
        end
    end

`ifdef VITERBI_LINK_ERR_INJ_EN
    localparam logic [16:0] LAST_SYM = 17'(FRAME_LEN + DEC_LAT - 1);

    logic [15:0] sym_ct;
    logic        sym_wrap;
    logic [15:0] err_start;
    logic [7:0]  err_len;
    logic [1:0]  err_mode;
    logic [16:0] win_end;
    logic        in_win;
    logic [1:0]  flips;
    logic [16:0] flip_sum;

    // Window bounds are 17-bit so start+len never wraps back into range
    assign win_end  = {1'b0, err_start} + {9'b0, err_len};
    assign in_win   = !sym_wrap
                   && ({1'b0, sym_ct} >= {1'b0, err_start})
                   && ({1'b0, sym_ct} <  win_end)
                   && ({1'b0, sym_ct} <= LAST_SYM);
    assign chan_err_o = (busy_o && enc_valid_i && in_win) ? err_mode : 2'b00;
    assign flips      = {1'b0, chan_err_o[1]} + {1'b0, chan_err_o[0]};
    assign flip_sum   = {1'b0, flip_ct} + {15'b0, flips};

    // Symbol counter, latched injection window and saturating flip count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_ct    <= '0;
            sym_wrap  <= 1'b0;
            err_start <= '0;
            err_len   <= '0;
            err_mode  <= '0;
            flip_ct   <= '0;
        end else if (start_ok) begin
            sym_ct    <= '0;
            sym_wrap  <= 1'b0;
            err_start <= err_start_i;
            err_len   <= err_len_i;
            err_mode  <= err_mode_i;
            flip_ct   <= '0;
        end else begin
            if (busy_o && enc_valid_i) begin
                sym_ct <= sym_ct + 16'd1;
                if (sym_ct == 16'hFFFF) sym_wrap <= 1'b1;
            end
            flip_ct <= flip_sum[16] ? 16'hFFFF : flip_sum[15:0];
        end
    end
`else
    logic unused_inj;

    assign chan_err_o = 2'b00;
    assign flip_ct    = 16'h0000;
    assign unused_inj = ^{err_start_i, err_len_i, err_mode_i, enc_valid_i};
`endif

    assign flip_ct_o = flip_ct;
    assign err_ct_o  = err_ct;
    assign pass_o    = pass_q;

endmodule

// File: tb/tb_viterbi_link_ctrl.sv
// Directed bench for viterbi_link_ctrl: loop-back decoder model, symbol
// valid delayed one cycle from encoder enable, frame-bit inversion hook.
`timescale 1ns/1ps
module tb_viterbi_link_ctrl;
    localparam int F = 256;
    localparam int L = 24;
`ifdef VITERBI_LINK_ERR_INJ_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] err_start_i = '0;
    logic [7:0]  err_len_i = '0;
    logic [1:0]  err_mode_i = '0;
    logic        enc_valid_i = 1'b0;
    logic        dec_bit_i = 1'b0;
    logic        enc_bit_o, enc_en_o, busy_o, done_o, pass_o;
    logic [1:0]  chan_err_o;
    logic [15:0] flip_ct_o, err_ct_o;

    viterbi_link_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .err_start_i(err_start_i), .err_len_i(err_len_i), .err_mode_i(err_mode_i),
        .enc_bit_o(enc_bit_o), .enc_en_o(enc_en_o), .enc_valid_i(enc_valid_i),
        .chan_err_o(chan_err_o), .dec_bit_i(dec_bit_i),
        .busy_o(busy_o), .done_o(done_o),
        .flip_ct_o(flip_ct_o), .err_ct_o(err_ct_o), .pass_o(pass_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    function automatic bit is_inv(input int n);
        return (n >= F) || n == 3 || n == 40 || n == 128 || n == 200 || n == 255;
    endfunction

    // Channel/decoder model: valid one cycle after enable, decoded bit is
    // the encoder bit from L cycles earlier, optionally inverted
    int          cyc = 0;
    int          n_en = 0;
    bit          inv_on = 1'b0;
    logic        en_last = 1'b0;
    logic [L-1:0] hist = '0;
    always @(posedge clk) begin
        #1;
        cyc++;
        enc_valid_i = en_last;
        en_last     = enc_en_o;
        dec_bit_i   = hist[L-1];
        hist        = {hist[L-2:0], enc_bit_o ^ (enc_en_o & inv_on & is_inv(n_en))};
    end

    // Observation of accepted starts, PRBS bits and corrupted symbols
    int          t_start = 0;
    int          n_done = 0;
    int          n_corr = 0;
    int          first_sym = -1;
    int          last_sym = -1;
    int          sym = 0;
    logic [1:0]  mask_or = '0;
    logic [31:0] bits = '0;
    always @(negedge clk) begin
        if (start_i && !busy_o && rst) begin
            t_start = cyc; n_en = 0; n_corr = 0; first_sym = -1; last_sym = -1;
            sym = 0; mask_or = '0; bits = '0;
        end
        if (done_o) n_done++;
        if (enc_en_o) begin
            if (n_en < 32) bits[n_en[4:0]] = enc_bit_o;
            n_en++;
        end
        if (chan_err_o != 2'b00) begin
            n_corr++;
            mask_or = mask_or | chan_err_o;
            if (first_sym < 0) first_sym = sym;
            last_sym = sym;
        end
        if (enc_valid_i && busy_o) sym++;
    end

    task automatic do_start(input logic [15:0] s, input logic [7:0] l, input logic [1:0] m);
        @(posedge clk); #1;
        err_start_i = s; err_len_i = l; err_mode_i = m; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    // Wait for done, check latency/counts; optionally restart right after DONE
    task automatic wait_done(input string tag, input int e_err, input int e_flip,
                             input int e_pass, input bit chain);
        int k = 0;
        while (!done_o && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, int'(done_o), 1);
        chk({tag, "_lat"}, cyc - t_start, F + L + 1);
        chk({tag, "_err"}, int'(err_ct_o), e_err);
        chk({tag, "_pass"}, int'(pass_o), e_pass);
        if (chain) begin
            @(posedge clk); #1;
            start_i = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_busy_fall"}, int'(busy_o), 0);
        chk({tag, "_flip"}, int'(flip_ct_o), e_flip);
        if (chain) begin
            @(posedge clk); #1;
            start_i = 1'b0;
        end
    endtask

    logic [15:0] s_model;

    initial begin
        // Second 16 PRBS bits from an independent parity-mask model
        s_model = 16'hACE1;
        for (int i = 0; i < 16; i++) s_model = {^(s_model & 16'h002D), s_model[15:1]};

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_en", int'(enc_en_o), 0);
        chk("rst_bit", int'(enc_bit_o), 0);
        chk("rst_chan", int'(chan_err_o), 0);
        chk("rst_flip", int'(flip_ct_o), 0);
        chk("rst_err", int'(err_ct_o), 0);
        chk("rst_pass", int'(pass_o), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Reset in the middle of RUN
        do_start(16'd0, 8'd0, 2'b00);
        repeat (99) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_en", int'(enc_en_o), 0);
        chk("midrst_err", int'(err_ct_o), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (300) @(negedge clk);
        chk("midrst_no_done", n_done, 0);
        chk("midrst_idle", int'(busy_o), 0);

        // Clean loop-back frame with defaults
        do_start(16'd0, 8'd0, 2'b00);
        wait_done("clean", 0, 0, 1, 1'b0);
        chk("clean_prbs_lo", int'(bits[15:0]), 16'hACE1);
        chk("clean_prbs_hi", int'(bits[31:16]), int'(s_model));
        chk("clean_en_cycles", n_en, F + L);
        chk("clean_n_done", n_done, 1);

        // Short window on the lower symbol bit
        do_start(16'd166, 8'd3, 2'b01);
        wait_done("inj3", 0, INJ ? 3 : 0, 1, 1'b0);
        chk("inj3_n", n_corr, INJ ? 3 : 0);
        chk("inj3_first", first_sym, INJ ? 166 : -1);
        chk("inj3_last", last_sym, INJ ? 168 : -1);
        chk("inj3_mask", int'(mask_or), INJ ? 1 : 0);

        // Window clipped at the last symbol of the frame
        do_start(16'd250, 8'd40, 2'b11);
        wait_done("clip", 0, INJ ? 60 : 0, 1, 1'b0);
        chk("clip_n", n_corr, INJ ? 30 : 0);
        chk("clip_first", first_sym, INJ ? 250 : -1);
        chk("clip_last", last_sym, INJ ? 279 : -1);
        chk("clip_mask", int'(mask_or), INJ ? 3 : 0);

        // Five inverted payload bits plus inverted tail; stray start in RUN
        inv_on = 1'b1;
        do_start(16'd0, 8'd0, 2'b00);
        repeat (50) @(posedge clk);
        #1 start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (220) @(negedge clk);
        inv_on = 1'b0;
        wait_done("inv", 5, 0, 0, 1'b1);

        // Back-to-back frame started the cycle after DONE
        @(negedge clk);
        chk("b2b_err_clr", int'(err_ct_o), 0);
        chk("b2b_en", int'(enc_en_o), 1);
        chk("b2b_first_bit", int'(enc_bit_o), 1);
        wait_done("b2b", 0, 0, 1, 1'b0);
        chk("b2b_prbs_lo", int'(bits[15:0]), 16'hACE1);
        chk("total_done", n_done, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/viterbi_link_ctrl.md
# viterbi_link_ctrl

Test sequencer for the encoder → channel → Viterbi decoder link. One `start` pulse runs one frame:
- drives a PRBS bit stream into the convolutional encoder;
- schedules a programmable burst of channel bit flips against encoder symbols;
- flushes the decoder;
- compares decoded bits against a latency-aligned copy of the transmitted bits.

It reports the injected-flip count, the decoded-error count and a pass flag, replacing the hard-coded error window and `$display` counting in the tx/rx wrapper.

## Interface
Parameters:
- `FRAME_LEN`, 256, payload bits per frame (2..65535).
- `DEC_LAT`, 24, cycles from `enc_bit_o` sampled (with `enc_en_o`=1) to the matching `dec_bit_i` (1..63).
- `LFSR_SEED`, 16'hACE1, PRBS seed; a value of 0 is replaced by 16'h0001.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  single-cycle frame start request.
- `err_start_i`  in  16  first channel-symbol index to corrupt; sampled at start.
- `err_len_i`  in  8  number of consecutive symbols to corrupt; 0 means none; sampled at start.
- `err_mode_i`  in  2  flip mask per corrupted symbol ({1,0} = {upper, lower} symbol bit); sampled at start.
- `enc_bit_o`  out  1  encoder data input.
- `enc_en_o`  out  1  encoder enable.
- `enc_valid_i`  in  1  encoder output-symbol valid.
- `chan_err_o`  out  2  XOR mask the channel register applies to the encoder symbol in the same cycle.
- `dec_bit_i`  in  1  decoder output bit.
- `busy_o`  out  1  frame in progress.
- `done_o`  out  1  one-cycle pulse at frame end.
- `flip_ct_o`  out  16  channel bits flipped this frame.
- `err_ct_o`  out  16  decoded bit mismatches this frame.
- `pass_o`  out  1  `err_ct_o`==0 at the last done; held until the next start.

## Operation
- **States:** IDLE, RUN, FLUSH, DONE.
- **IDLE → RUN** on `start_i`. On start:
  - LFSR loads `LFSR_SEED`;
  - bit counter, symbol counter, `flip_ct_o` and `err_ct_o` clear;
  - `err_start_i`, `err_len_i` and `err_mode_i` are latched.
- `start_i` is ignored outside IDLE.
- **RUN** lasts exactly `FRAME_LEN` cycles:
  - `enc_en_o`=1 and `enc_bit_o`=LFSR[0];
  - the LFSR steps each cycle: Fibonacci, x^16+x^14+x^13+x^11+1, shift toward bit 0, feedback into bit 15;
  - each `enc_bit_o` is pushed into a `DEC_LAT`-deep reference shift register, together with a tag bit set to 1.
- **RUN → FLUSH** after the bit counter reaches `FRAME_LEN`-1.
- **FLUSH** lasts `DEC_LAT` cycles:
  - `enc_en_o`=1 and `enc_bit_o`=0 (tail bits);
  - tail bits are pushed into the reference pipe with tag=0.
- **FLUSH → DONE → IDLE.** DONE lasts one cycle with `done_o`=1, and `pass_o` updates in that cycle.
- **Symbol counter:** increments on every `enc_valid_i` while `busy_o`=1. It wraps at 65535; past that point no further injection occurs.
- **Injection:** while `busy_o`=1 and `enc_valid_i`=1:
  - `chan_err_o` = latched mode if err_start ≤ symbol index < err_start+err_len (computed 17-bit, no wrap), else `chan_err_o`=0;
  - symbols beyond `FRAME_LEN`+`DEC_LAT`-1 are never corrupted.
- **Flip count:** `flip_ct_o` += popcount(`chan_err_o`) per cycle.
- **Comparison:** on every cycle whose reference-pipe output tag=1, `err_ct_o` += (`dec_bit_i` ^ ref bit). Exactly `FRAME_LEN` comparisons are made per frame.
- **Counters:** all counters saturate at 16'hFFFF.
- Counts hold their final values in IDLE until the next start.

## Timing
- **Reset values:** all outputs 0, state IDLE, LFSR = seed, reference pipe and tags cleared.
- **Reset mid-frame:** same as above; no `done_o` pulse is produced.
- **Start latency:** `start_i` in cycle t gives `enc_en_o`=1 in cycle t+1. The first PRBS bit is `LFSR_SEED`[0].
- **`chan_err_o`:** combinational from registered state and `enc_valid_i`; no added latency.
- **Compare alignment:** the bit driven in cycle c is compared with `dec_bit_i` in cycle c+`DEC_LAT`.
- **Frame length:** `done_o` rises in cycle t+1+`FRAME_LEN`+`DEC_LAT`, and `busy_o` falls in the following cycle.
- **Back-to-back frames:** a `start_i` in the cycle after DONE is accepted. The minimum frame period is `FRAME_LEN`+`DEC_LAT`+2 cycles.

## Configuration
- **Macro:** `VITERBI_LINK_ERR_INJ_EN`.
- **Defined:** injection logic is built as described.
- **Undefined:**
  - `chan_err_o` is tied to 2'b00 and `flip_ct_o` stays 0;
  - `err_*_i` inputs are ignored;
  - sequencing and comparison are unchanged.

## Test plan
- Reset asserted mid-RUN (cycle 100) → all outputs 0 and IDLE; the next start runs a full frame with correct counts.
- Defaults, `err_len_i`=0, loop-back model (`dec_bit_i` = `enc_bit_o` delayed 24) → `done_o` at t+281, `flip_ct_o`=0, `err_ct_o`=0, `pass_o`=1.
- `err_start_i`=166, `err_len_i`=3, `err_mode_i`=2'b01, `enc_valid_i` one cycle after `enc_en_o` → `chan_err_o`=01 on symbols 166–168 only, `flip_ct_o`=3.
- `err_mode_i`=2'b11, `err_start_i`=250, `err_len_i`=40 → `flip_ct_o`=2×30=60 (window clipped at symbol 279).
- Loop-back with `dec_bit_i` inverted on 5 frame bits and on all tail cycles → `err_ct_o`=5, `pass_o`=0.
- `start_i` pulsed during RUN, then again one cycle after `done_o` → first pulse ignored; second frame starts, counters cleared, PRBS restarts from the seed.
